// File: rtl/pwm_pkg.sv
// pwm_pkg: register map, bit indices, bus-decode enum and byte-strobe merge
// shared by the pwm_multi peripheral.
package pwm_pkg;

  localparam logic [7:0] OFF_CTRL      = 8'h00;
  localparam logic [7:0] OFF_PERIOD    = 8'h04;
  localparam logic [7:0] OFF_PRESCALE  = 8'h08;
  localparam logic [7:0] OFF_COUNT     = 8'h0C;
  localparam logic [7:0] OFF_IRQ       = 8'h10;
  localparam logic [7:0] OFF_DUTY_BASE = 8'h20;

  localparam int CTRL_EN_BIT  = 0;
  localparam int IRQ_FLAG_BIT = 0;
  localparam int IRQ_IE_BIT   = 1;

  typedef enum logic [2:0] {
    DEC_NONE,
    DEC_CTRL,
    DEC_PERIOD,
    DEC_PRESCALE,
    DEC_COUNT,
    DEC_IRQ,
    DEC_DUTY
  } dec_e;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] wdata_v,
                                             input logic [3:0]  strb_v);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (strb_v[b]) r[8*b +: 8] = wdata_v[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one PWM lane -- duty shadow/active pair, compare against the
// shared counter, registered output.
module pwm_channel #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] count_i,
  input  logic             wrap_i,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] duty_o,
  output logic             pwm_o
);

  logic [WIDTH-1:0] duty_sh_q, duty_act_q;
  logic             pwm_q;

  // Active copy is taken from the pre-write shadow, so a write landing on
  // the wrap cycle is deferred to the following wrap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      duty_sh_q  <= '0;
      duty_act_q <= '0;
      pwm_q      <= 1'b0;
    end else begin
      if (we_i) duty_sh_q <= wdata_i;
      if (wrap_i || !en_i) duty_act_q <= duty_sh_q;
      pwm_q <= en_i & (count_i < duty_act_q);
    end
  end

  assign duty_o = duty_sh_q;
  assign pwm_o  = pwm_q;

endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM on the valid/ready bus with a shared prescaler
// and period counter. Define PWM_IRQ_EN to build the period-wrap IRQ register.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                valid,
  output logic                ready,
  input  logic [3:0]          wstrb,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic [CHANNELS-1:0] out,
  output logic                irq
);

  logic                           ready_q;
  logic [31:0]                    rdata_q;
  logic                           en_q;
  logic [WIDTH-1:0]               period_sh_q, period_act_q, count_q, count_d;
  logic [PRESCALE_W-1:0]          prescale_q, presc_q, presc_d;
  logic [CHANNELS-1:0][WIDTH-1:0] duty_sh;
  logic [CHANNELS-1:0]            duty_we;
  dec_e                           dec;
  logic [5:0]                     widx;
  logic [31:0]                    duty_old, rd_val, wr_val;
  logic                           accept, wr, rd, tick, wrap;
  logic                           unused_addr;
`ifdef PWM_IRQ_EN
  logic                           flag_q, ie_q, irq_q, irq_wr;
`endif

  assign unused_addr = ^{addr[31:8], addr[1:0]};
  assign widx   = addr[7:2];
  assign accept = valid & ~ready_q;
  assign wr     = accept & (|wstrb);
  assign rd     = accept & ~(|wstrb);

  always_comb begin
    dec      = DEC_NONE;
    duty_old = '0;
    duty_we  = '0;
    if      (widx == OFF_CTRL[7:2])     dec = DEC_CTRL;
    else if (widx == OFF_PERIOD[7:2])   dec = DEC_PERIOD;
    else if (widx == OFF_PRESCALE[7:2]) dec = DEC_PRESCALE;
    else if (widx == OFF_COUNT[7:2])    dec = DEC_COUNT;
`ifdef PWM_IRQ_EN
    else if (widx == OFF_IRQ[7:2])      dec = DEC_IRQ;
`endif
    for (int i = 0; i < CHANNELS; i++) begin
      if (int'(widx) == int'(OFF_DUTY_BASE[7:2]) + i) begin
        dec        = DEC_DUTY;
        duty_old   = 32'(duty_sh[i]);
        duty_we[i] = wr;
      end
    end
  end

  // Readback doubles as the merge base for strobed writes.
  always_comb begin
    rd_val = '0;
    case (dec)
      DEC_CTRL:     rd_val[CTRL_EN_BIT] = en_q;
      DEC_PERIOD:   rd_val = 32'(period_sh_q);
      DEC_PRESCALE: rd_val = 32'(prescale_q);
      DEC_COUNT:    rd_val = 32'(count_q);
      DEC_DUTY:     rd_val = duty_old;
`ifdef PWM_IRQ_EN
      DEC_IRQ: begin
        rd_val[IRQ_FLAG_BIT] = flag_q;
        rd_val[IRQ_IE_BIT]   = ie_q;
      end
`endif
      default: ;
    endcase
  end

  assign wr_val = apply_strb(rd_val, wdata, wstrb);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      en_q        <= 1'b0;
      period_sh_q <= '0;
      prescale_q  <= '0;
    end else begin
      ready_q <= accept;
      rdata_q <= rd ? rd_val : '0;
      if (wr && dec == DEC_CTRL)     en_q        <= wr_val[CTRL_EN_BIT];
      if (wr && dec == DEC_PERIOD)   period_sh_q <= wr_val[WIDTH-1:0];
      if (wr && dec == DEC_PRESCALE) prescale_q  <= wr_val[PRESCALE_W-1:0];
    end
  end

  // >= keeps the prescaler sane if PRESCALE is lowered below the running count.
  assign tick = en_q && (presc_q >= prescale_q);
  assign wrap = tick && (count_q == period_act_q);

  always_comb begin
    presc_d = presc_q + 1'b1;
    count_d = count_q;
    if (!en_q) begin
      presc_d = '0;
      count_d = '0;
    end else if (tick) begin
      presc_d = '0;
      count_d = wrap ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc_q      <= '0;
      count_q      <= '0;
      period_act_q <= '0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      if (wrap || !en_q) period_act_q <= period_sh_q;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_channel #(.WIDTH(WIDTH)) u_ch (
      .clk_i   (clk),
      .rst_ni  (resetn),
      .count_i (count_q),
      .wrap_i  (wrap),
      .en_i    (en_q),
      .we_i    (duty_we[i]),
      .wdata_i (wr_val[WIDTH-1:0]),
      .duty_o  (duty_sh[i]),
      .pwm_o   (out[i])
    );
  end

`ifdef PWM_IRQ_EN
  assign irq_wr = wr && (dec == DEC_IRQ) && wstrb[0];

  // A wrap in the same cycle as a W1C keeps the flag set.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      flag_q <= 1'b0;
      ie_q   <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      flag_q <= wrap | (flag_q & ~(irq_wr & wdata[IRQ_FLAG_BIT]));
      if (irq_wr) ie_q <= wdata[IRQ_IE_BIT];
      irq_q <= flag_q & ie_q;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  assign ready = ready_q;
  assign rdata = rdata_q;

endmodule
